// File: rtl/lapido_core_datapath_if.sv
// Bus bundle for the Lapido datapath slice: ALU operands/result/flags,
// PC incrementer and boot ROM stream.
interface lapido_core_datapath_if;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_opcode;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        alu_carry;
    logic        alu_overflow;
    logic        alu_negative;
    logic [31:0] pc_in;
    logic [31:0] pc_next;
    logic [31:0] boot_data;
    logic [7:0]  boot_addr;
    logic        boot_valid;
    logic        boot_done;

    modport master (
        output alu_a, alu_b, alu_opcode, pc_in,
        input  alu_out, alu_zero, alu_carry, alu_overflow, alu_negative,
        input  pc_next, boot_data, boot_addr, boot_valid, boot_done
    );

    modport slave (
        input  alu_a, alu_b, alu_opcode, pc_in,
        output alu_out, alu_zero, alu_carry, alu_overflow, alu_negative,
        output pc_next, boot_data, boot_addr, boot_valid, boot_done
    );
endinterface

// File: rtl/lapido_core_datapath.sv
// Lapido datapath slice: combinational EX-stage ALU, IF-stage PC incrementer
// and a boot ROM streamer that emits BOOT_WORDS words after reset.
module lapido_core_datapath #(
    parameter int          BOOT_WORDS = 6,
    parameter logic [31:0] BOOT_BASE  = 32'hB1050000
) (
    input  logic                  clock,
    input  logic                  reset,
    lapido_core_datapath_if.slave bus
);

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3,
        OP_XOR  = 5'd4,  OP_NOT  = 5'd5,  OP_SLL  = 5'd6,  OP_SRL  = 5'd7,
        OP_SRA  = 5'd8,  OP_SLT  = 5'd9,  OP_SLTU = 5'd10, OP_PASB = 5'd11,
        OP_PASA = 5'd12, OP_INC  = 5'd13, OP_DEC  = 5'd14
    } alu_op_e;

    typedef enum logic [1:0] {S_START, S_STREAM, S_DONE} boot_state_e;

    localparam logic [7:0] LAST_IDX = 8'(BOOT_WORDS - 1);

    logic signed [31:0] a_s, b_s;
    logic        [31:0] rhs;
    logic        [32:0] sum_w, diff_w;
    logic        [4:0]  shamt;
    logic        [31:0] result;
    logic               carry, ovf;

    assign a_s   = bus.alu_a;
    assign b_s   = bus.alu_b;
    assign shamt = bus.alu_b[4:0];

    // INC/DEC reuse the add/subtract paths with a constant 1 as the second operand.
    always_comb begin
        rhs = bus.alu_b;
        if (bus.alu_opcode == OP_INC || bus.alu_opcode == OP_DEC) rhs = 32'd1;
    end

    assign sum_w  = {1'b0, bus.alu_a} + {1'b0, rhs};
    assign diff_w = {1'b0, bus.alu_a} - {1'b0, rhs};

    always_comb begin
        result = 32'd0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (alu_op_e'(bus.alu_opcode))
            OP_ADD, OP_INC: begin
                result = sum_w[31:0];
                carry  = sum_w[32];
                ovf    = (bus.alu_a[31] == rhs[31]) && (sum_w[31] != bus.alu_a[31]);
            end
            OP_SUB, OP_DEC: begin
                result = diff_w[31:0];
                carry  = diff_w[32];
                ovf    = (bus.alu_a[31] != rhs[31]) && (diff_w[31] != bus.alu_a[31]);
            end
            OP_AND:  result = bus.alu_a & bus.alu_b;
            OP_OR:   result = bus.alu_a | bus.alu_b;
            OP_XOR:  result = bus.alu_a ^ bus.alu_b;
            OP_NOT:  result = ~bus.alu_a;
            OP_SLL:  result = bus.alu_a << shamt;
            OP_SRL:  result = bus.alu_a >> shamt;
            OP_SRA:  result = a_s >>> shamt;
            OP_SLT:  result = {31'd0, (a_s < b_s)};
            OP_SLTU: result = {31'd0, (bus.alu_a < bus.alu_b)};
            OP_PASB: result = bus.alu_b;
            OP_PASA: result = bus.alu_a;
            default: result = 32'd0;
        endcase
    end

    assign bus.alu_out      = result;
    assign bus.alu_zero     = (result == 32'd0);
    assign bus.alu_carry    = carry;
    assign bus.alu_overflow = ovf;
    assign bus.alu_negative = result[31];

    assign bus.pc_next = bus.pc_in + 32'd1;

    boot_state_e state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_START;
            idx_q   <= 8'd0;
            data_q  <= 32'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // idx_q always names the word currently on boot_data; it stops at the last word.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        done_d  = done_q;
        case (state_q)
            S_START: begin
                idx_d   = 8'd0;
                data_d  = BOOT_BASE;
                valid_d = 1'b1;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (idx_q == LAST_IDX) begin
                    data_d  = 32'd0;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d  = idx_q + 8'd1;
                    data_d = BOOT_BASE + 32'(idx_q) + 32'd1;
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_START;
        endcase
    end

    assign bus.boot_data  = data_q;
    assign bus.boot_addr  = idx_q;
    assign bus.boot_valid = valid_q;
    assign bus.boot_done  = done_q;

endmodule

// File: tb/tb_lapido_core_datapath.sv
// Self-checking bench for lapido_core_datapath: directed and random ALU/PC
// checks against an arithmetic reference model, plus boot stream sequencing.
module tb_lapido_core_datapath;

    localparam logic [31:0] BASE = 32'hB1050000;
    localparam int          NW   = 6;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    lapido_core_datapath_if bus_if ();

    lapido_core_datapath #(.BOOT_WORDS(NW), .BOOT_BASE(BASE)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic ovf64(input longint x);
        return (x > 64'sd2147483647) || (x < -64'sd2147483648);
    endfunction

    // Reference ALU computed in 64-bit integer arithmetic.
    function automatic void alu_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output logic c, output logic v);
        longint ua, ub, sa, sb, t;
        int     sh;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b[4:0]);
        t  = 0;
        r  = 32'd0;
        c  = 1'b0;
        v  = 1'b0;
        case (op)
            5'd0:  begin t = ua + ub; r = t[31:0]; c = t[32]; v = ovf64(sa + sb); end
            5'd1:  begin t = ua - ub; r = t[31:0]; c = (ua < ub); v = ovf64(sa - sb); end
            5'd2:  r = a & b;
            5'd3:  r = a | b;
            5'd4:  r = a ^ b;
            5'd5:  r = ~a;
            5'd6:  r = a << sh;
            5'd7:  r = a >> sh;
            5'd8:  begin t = sa >>> sh; r = t[31:0]; end
            5'd9:  r = (sa < sb) ? 32'd1 : 32'd0;
            5'd10: r = (ua < ub) ? 32'd1 : 32'd0;
            5'd11: r = b;
            5'd12: r = a;
            5'd13: begin t = ua + 1; r = t[31:0]; c = t[32]; v = ovf64(sa + 1); end
            5'd14: begin t = ua - 1; r = t[31:0]; c = (ua < 1); v = ovf64(sa - 1); end
            default: r = 32'd0;
        endcase
    endfunction

    task automatic alu_expect(input string tag, input logic [4:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] e_out, input logic e_c, input logic e_v);
        bus_if.alu_opcode = op;
        bus_if.alu_a      = a;
        bus_if.alu_b      = b;
        #1;
        check({tag, "/out"},  bus_if.alu_out, e_out);
        check({tag, "/zero"}, {31'd0, bus_if.alu_zero}, {31'd0, (e_out == 32'd0)});
        check({tag, "/carry"}, {31'd0, bus_if.alu_carry}, {31'd0, e_c});
        check({tag, "/ovf"},  {31'd0, bus_if.alu_overflow}, {31'd0, e_v});
        check({tag, "/neg"},  {31'd0, bus_if.alu_negative}, {31'd0, e_out[31]});
    endtask

    task automatic boot_expect(input string tag, input logic [31:0] d, input logic [7:0] ad,
                               input logic vl, input logic dn, input logic chk_addr);
        check({tag, "/data"},  bus_if.boot_data, d);
        if (chk_addr) check({tag, "/addr"}, {24'd0, bus_if.boot_addr}, {24'd0, ad});
        check({tag, "/valid"}, {31'd0, bus_if.boot_valid}, {31'd0, vl});
        check({tag, "/done"},  {31'd0, bus_if.boot_done}, {31'd0, dn});
    endtask

    task automatic edge_sample();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        logic [31:0] r, a, b, pc;
        logic        c, v;
        logic [4:0]  op;
        logic [31:0] specials [6];

        specials[0] = 32'h00000000; specials[1] = 32'hFFFFFFFF; specials[2] = 32'h7FFFFFFF;
        specials[3] = 32'h80000000; specials[4] = 32'h00000001; specials[5] = 32'h0000001F;

        reset             = 1'b0;
        bus_if.alu_a      = 32'd0;
        bus_if.alu_b      = 32'd0;
        bus_if.alu_opcode = 5'd0;
        bus_if.pc_in      = 32'd0;
        #1;
        boot_expect("reset", 32'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        #1 reset = 1'b1;

        for (int i = 0; i < NW; i++) begin
            edge_sample();
            boot_expect($sformatf("boot_w%0d", i), BASE + 32'(i), 8'(i), 1'b1, 1'b0, 1'b1);
        end
        edge_sample();
        boot_expect("boot_end", 32'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        for (int e = NW + 2; e <= 20; e++) edge_sample();
        boot_expect("boot_hold20", 32'd0, 8'd0, 1'b0, 1'b1, 1'b0);

        // Restart the stream, then interrupt it while word 2 is showing.
        reset = 1'b0;
        #1;
        boot_expect("rst_after_done", 32'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            edge_sample();
            boot_expect($sformatf("restream_w%0d", i), BASE + 32'(i), 8'(i), 1'b1, 1'b0, 1'b1);
        end
        reset = 1'b0;
        #1;
        boot_expect("rst_midstream", 32'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        edge_sample();
        boot_expect("rst_held_edge", 32'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        edge_sample();
        boot_expect("post_rst_w0", BASE, 8'd0, 1'b1, 1'b0, 1'b1);
        edge_sample();
        boot_expect("post_rst_w1", BASE + 32'd1, 8'd1, 1'b1, 1'b0, 1'b1);

        alu_expect("add_ovf",  5'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1);
        alu_expect("add_wrap", 5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0);
        alu_expect("sub_eq",   5'd1,  32'd5, 32'd5, 32'h00000000, 1'b0, 1'b0);
        alu_expect("sub_brw",  5'd1,  32'd3, 32'd5, 32'hFFFFFFFE, 1'b1, 1'b0);
        alu_expect("slt",      5'd9,  32'h80000000, 32'd1, 32'd1, 1'b0, 1'b0);
        alu_expect("sltu",     5'd10, 32'h80000000, 32'd1, 32'd0, 1'b0, 1'b0);
        alu_expect("sll",      5'd6,  32'h80000001, 32'h00000024, 32'h00000010, 1'b0, 1'b0);
        alu_expect("srl",      5'd7,  32'h80000001, 32'h00000024, 32'h08000000, 1'b0, 1'b0);
        alu_expect("sra",      5'd8,  32'h80000001, 32'h00000024, 32'hF8000000, 1'b0, 1'b0);
        alu_expect("sh0",      5'd8,  32'h80000001, 32'h00000020, 32'h80000001, 1'b0, 1'b0);
        alu_expect("bad_op",   5'd31, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b0);
        alu_expect("inc_wrap", 5'd13, 32'hFFFFFFFF, 32'h0, 32'h00000000, 1'b1, 1'b0);
        alu_expect("dec_ovf",  5'd14, 32'h80000000, 32'h0, 32'h7FFFFFFF, 1'b0, 1'b1);

        for (int n = 0; n < 300; n++) begin
            op = 5'($urandom_range(0, 31));
            a  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            alu_model(op, a, b, r, c, v);
            alu_expect($sformatf("rnd%0d_op%0d", n, op), op, a, b, r, c, v);
        end

        bus_if.pc_in = 32'h00000000; #1 check("pc_0",    bus_if.pc_next, 32'h00000001);
        bus_if.pc_in = 32'h0000000F; #1 check("pc_f",    bus_if.pc_next, 32'h00000010);
        bus_if.pc_in = 32'hFFFFFFFF; #1 check("pc_wrap", bus_if.pc_next, 32'h00000000);
        for (int n = 0; n < 20; n++) begin
            pc = $urandom;
            bus_if.pc_in = pc;
            #1 check("pc_rnd", bus_if.pc_next, 32'((longint'({32'd0, pc}) + 1) % 64'h100000000));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
